// File: rtl/bus_arbiter_mux_pkg.sv
// Shared types for the bus arbiter/mux: controller states and arbitration mode constants.
package bus_arbiter_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Request/data inputs and registered bus outputs of the arbiter/mux.
// The master modport belongs to the request side; the slave modport belongs to the arbiter.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 32
);
  localparam int SEL_W = $clog2(N_SRC);

  logic [N_SRC-1:0]       src_req;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   fault_ack;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SEL_W-1:0]       bus_sel;
  logic                   multi_drive;
  logic                   fault;

  modport master (
    output src_req, src_data, fault_ack,
    input  bus_out, bus_valid, bus_sel, multi_drive, fault
  );

  modport slave (
    input  src_req, src_data, fault_ack,
    output bus_out, bus_valid, bus_sel, multi_drive, fault
  );
endinterface

// File: rtl/bus_arb_pick.sv
// Combinational picker: first set request at or above start, wrapping modulo N_SRC.
// Zero latency; also flags any request and more than one request.
module bus_arb_pick #(
  parameter  int N_SRC = 32,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] winner,
  output logic             any,
  output logic             multi
);

  int idx;
  int cnt;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cnt    = 0;
    // Wrap by subtraction so non-power-of-two N_SRC never yields an index past N_SRC-1.
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(start) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (req[idx] && !any) begin
        winner = SEL_W'(idx);
        any    = 1'b1;
      end
      cnt = cnt + int'(req[k]);
    end
    multi = (cnt > 1);
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered N_SRC-to-1 bus mux with fixed-priority or round-robin arbitration and sticky multi-driver fault.
// Latency 1 cycle from request to bus_out; no backpressure, requests are single-cycle and never queued.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SRC    = 32,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic               clock,
  input  logic               clear,
  bus_arbiter_mux_if.slave   bus
);

  localparam int SEL_W = $clog2(N_SRC);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             multi;
  logic [WIDTH-1:0] win_data;

  assign start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  bus_arb_pick #(.N_SRC(N_SRC)) u_pick (
    .req    (bus.src_req),
    .start  (start),
    .winner (winner),
    .any    (any),
    .multi  (multi)
  );

  assign win_data  = bus.src_data[int'(winner)*WIDTH +: WIDTH];
  assign bus.fault = (state == FAULT);

  // A new conflict beats an acknowledge arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    if (multi)
      state_nxt = FAULT;
    else if (state == FAULT && !bus.fault_ack)
      state_nxt = FAULT;
    else if (any)
      state_nxt = DRIVE;
    else
      state_nxt = IDLE;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      bus.bus_out     <= '0;
      bus.bus_sel     <= '0;
      bus.bus_valid   <= 1'b0;
      bus.multi_drive <= 1'b0;
    end else begin
      state           <= state_nxt;
      bus.bus_valid   <= any;
      bus.multi_drive <= multi;
      if (any) begin
        bus.bus_out <= win_data;
        bus.bus_sel <= winner;
        rr_ptr      <= (winner == SEL_W'(N_SRC - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

endmodule

// File: doc/bus_arbiter_mux.md
# bus_arbiter_mux

Parametrised, registered successor to the datapath's 32-to-1 bus encoder/multiplexer. Takes N_SRC request lines (the register/PC/MDR "out" enables) plus their data words, selects one source each cycle by fixed-priority or round-robin arbitration, and drives a registered bus word with valid and select indication. Detects multiple simultaneous drivers and latches a sticky fault for the control unit. Sits between the register file/special registers and the shared datapath bus.

## Interface
- WIDTH, 32, data width of each source and of the bus
- N_SRC, 32, number of sources, 2..64
- SEL_W, $clog2(N_SRC), width of the select index (derived, not overridden)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- clock  in  1  single clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- src_req  in  N_SRC  per-source drive request (one-hot expected)
- src_data  in  N_SRC*WIDTH  packed source words, source i at bits [i*WIDTH +: WIDTH]
- fault_ack  in  1  clears sticky fault
- bus_out  out  WIDTH  registered bus word
- bus_valid  out  1  bus_out carries a source selected this cycle
- bus_sel  out  SEL_W  index of source driving bus_out
- multi_drive  out  1  registered flag: >1 request seen this cycle
- fault  out  1  sticky: set on any multi_drive, held until fault_ack

## Operation
- States: IDLE, DRIVE, FAULT. Reset -> IDLE.
- IDLE: no request. bus_out and bus_sel hold last value; bus_valid=0.
- Any request (IDLE or DRIVE): winner chosen, bus_out <= src_data[winner], bus_sel <= winner, bus_valid <= 1, next DRIVE.
- DRIVE with no request -> IDLE, bus_valid <= 0, data held.
- Fixed priority: winner = lowest set index.
- Round-robin: pointer rr_ptr; winner = first set index at or above rr_ptr, wrapping modulo N_SRC; after a grant rr_ptr <= winner+1, wrapping N_SRC-1 -> 0. rr_ptr unchanged when no request.
- Conflict (popcount(src_req) > 1): arbitration still grants normally (bus never goes X); multi_drive <= 1 that cycle; fault set; state -> FAULT.
- FAULT: arbitration and bus continue as in DRIVE/IDLE; fault stays 1. fault_ack with no new conflict -> fault <= 0, state to IDLE/DRIVE per requests. Conflict in the same cycle as fault_ack: fault stays 1 (set wins).
- WIDTH arithmetic: none; data passed bit-exact. Index arithmetic done modulo N_SRC, not 2^SEL_W, for non-power-of-two N_SRC.

## Timing
- Latency 1 cycle: src_req/src_data sampled at edge k, visible on bus_out/bus_valid/bus_sel after edge k.
- multi_drive valid same cycle as corresponding bus_out; fault rises with it.
- No backpressure; a request is single-cycle and never queued.
- Reset values: bus_out=0, bus_valid=0, bus_sel=0, multi_drive=0, fault=0, rr_ptr=0, state IDLE.
- clear asserted mid-transfer: outputs go to reset values immediately (asynchronously); first edge after deassertion samples fresh requests.
- Throughput: one grant per cycle, back-to-back from different sources allowed.

## Structure
- Shared package holds state enum (IDLE/DRIVE/FAULT) and ARB_MODE constants (ARB_FIXED=0, ARB_RR=1).
- One sub-module: bus_arb_pick — combinational N_SRC-bit picker taking req and start pointer, returning winner index and any/multi flags; fixed mode ties pointer to 0.
- Top holds state register, rr_ptr, output registers, fault latch.

## Test plan
- Sweep: src_data[i] = 2*(i+1), one-hot src_req = 1<<i for i = 0..31, one per cycle -> bus_out = 2*(i+1), bus_sel = i, bus_valid = 1, one cycle after each request, multi_drive = 0.
- Idle hold: request source 5 then src_req = 0 for 3 cycles -> bus_out stays 12, bus_valid = 0, bus_sel = 5.
- Conflict, fixed mode: src_req = bits 3 and 7 -> bus_out = 8, bus_sel = 3, multi_drive = 1, fault = 1 held; fault_ack with one-hot request -> fault = 0 next cycle; fault_ack with simultaneous conflict -> fault stays 1.
- Round-robin, ARB_MODE=1: src_req = bits 0,4,31 held 4 cycles -> bus_sel = 0, 4, 31, 0 (wrap).
- Non-power-of-two N_SRC=5, RR: all requests set -> bus_sel 0,1,2,3,4,0; never 5..7.
- Reset mid-operation: assert clear between edges while bus_valid = 1 -> bus_out = 0, bus_valid = 0, fault = 0 immediately; after release, request source 2 -> bus_out = 6 one cycle later, rr_ptr restarted at 0.
